// File: rtl/mul_pkg.sv
// Shared definitions for the multi-cycle multiply unit: FSM states, operand
// width and the decoder opcodes that select signed or unsigned operation.
package mul_pkg;

    localparam int unsigned MUL_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_e;

    // Execute-stage opcodes; the decoder turns these into is_signed.
    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_MULS = 2'd1;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULS) && (op != OP_MUL);
    endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Radix-2 shift-add datapath: holds |A| and the {carry, hi, lo} accumulator,
// loads operand magnitudes on load and performs one add/shift per step.
module mul_shift_add_dp #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 add,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 lsb,
    output logic [2*WIDTH-1:0]   acc_prod
);

    localparam int unsigned ACC_W = 2 * WIDTH + 1;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   sum;

    // Operand magnitudes; the most negative value maps onto itself as unsigned.
    always_comb begin
        mag_a = multiplicand;
        mag_b = multiplier;
        if (is_signed && multiplicand[WIDTH-1]) begin
            mag_a = ~multiplicand + WIDTH'(1);
        end
        if (is_signed && multiplier[WIDTH-1]) begin
            mag_b = ~multiplier + WIDTH'(1);
        end
    end

    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        sum     = {acc_q[ACC_W-1], acc_q[2*WIDTH-1:WIDTH]}
                + (add ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        if (load) begin
            mcand_d = mag_a;
            acc_d   = {1'b0, {WIDTH{1'b0}}, mag_b};
        end else if (step) begin
            acc_d   = {1'b0, sum, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q <= '0;
            acc_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
        end
    end

    assign lsb      = acc_q[0];
    assign acc_prod = acc_q[2*WIDTH-1:0];

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply controller: sequences WIDTH shift-add steps, applies
// sign correction and returns a registered product with a one-cycle done.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [PW-1:0]    product_q, product_d;

    logic             load_c, step_c, add_c;
    logic             lsb;
    logic [PW-1:0]    acc_prod;

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load_c),
        .step         (step_c),
        .add          (add_c),
        .is_signed    (is_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .lsb          (lsb),
        .acc_prod     (acc_prod)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        load_c    = 1'b0;
        step_c    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // abort only matters in DONE, where it beats a same-cycle start
                if (state_q == ST_DONE && abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    load_c  = 1'b1;
                    neg_d   = is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    step_c = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    product_d = neg_q ? (~acc_prod + PW'(1)) : acc_prod;
                    state_d   = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        add_c  = step_c & lsb;
        busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
        done_d = (state_q == ST_FIX) && (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
